// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one byte-wide UART transmitter among NUM_REQ producers.
// Define UART_TX_SCHED_TIMEOUT_EN to abort a launch the transmitter never acknowledges with busy.
module uart_tx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 sched_busy,
  output logic                 err_timeout
);

  if (ID_W != $clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("uart_tx_scheduler: inconsistent parameters");
  end

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                    state;
  logic [ID_W-1:0]           ptr;
  logic [ID_W-1:0]           win;
  logic [ID_W-1:0]           cand;
  logic                      win_vld;
  logic [NUM_REQ-1:0][7:0]   req_bytes;

  assign req_bytes = req_data;

  // Walk from farthest to nearest so the requester closest after ptr wins.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= ID_W'(NUM_REQ - 1);
      tx_start   <= 1'b0;
      tx_data    <= '0;
      ack        <= '0;
      grant_id   <= '0;
      sched_busy <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      cnt         <= '0;
      err_timeout <= 1'b0;
`endif
    end else begin
      tx_start <= 1'b0;
      ack      <= '0;
      case (state)
        IDLE: begin
          if (win_vld && !tx_busy) begin
            tx_data    <= req_bytes[win];
            grant_id   <= win;
            tx_start   <= 1'b1;
            ack        <= NUM_REQ'(1) << win;
            sched_busy <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          state <= WAIT_BUSY;
`ifdef UART_TX_SCHED_TIMEOUT_EN
          cnt   <= '0;
`endif
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end
`ifdef UART_TX_SCHED_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            // Abandon the frame; the ack already given stands.
            err_timeout <= 1'b1;
            ptr         <= grant_id;
            sched_busy  <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            ptr        <= grant_id;
            sched_busy <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with an 11-cycle transmitter busy model.
// Timeout section follows UART_TX_SCHED_TIMEOUT_EN.
module tb_uart_tx_scheduler;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        sched_busy;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  logic       model_en;
  int         busy_cnt;

  uart_tx_scheduler #(.NUM_REQ(4), .ID_W(2), .TIMEOUT(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .grant_id   (grant_id),
    .sched_busy (sched_busy),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter: busy for 11 cycles starting the cycle after transmit.
  initial busy_cnt = 0;
  always @(posedge clk) begin
    if (tx_start && model_en) busy_cnt <= 11;
    else if (busy_cnt != 0)   busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = model_en && (busy_cnt != 0);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_launch(input int budget);
    int n;
    n = 0;
    while (tx_start !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check("launch_seen", {31'd0, tx_start}, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (sched_busy !== 1'b0 && n < budget) begin
      step();
      n++;
    end
    check("idle_seen", {31'd0, sched_busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] rr_data [5];
    logic [1:0] rr_id   [5];
    rr_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    rr_id   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Reset held with every requester pending.
    reset_n  = 1'b0;
    model_en = 1'b1;
    req      = 4'b1111;
    req_data = 32'h44332211;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_ack", ack, 0);
      check("rst_tx_start", tx_start, 0);
    end
    check("rst_tx_data", tx_data, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_sched_busy", sched_busy, 0);
    check("rst_err_timeout", err_timeout, 0);
    req = 4'b0000;
    reset_n = 1'b1;
    step();
    step();
    check("post_rst_idle", {tx_start, sched_busy}, 0);

    // Round robin with all four pending: 0,1,2,3,0.
    req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      wait_launch(40);
      check("rr_ack", ack, 4'b0001 << rr_id[f]);
      check("rr_grant_id", grant_id, rr_id[f]);
      check("rr_tx_data", tx_data, rr_data[f]);
      if (f == 4) req = 4'b0000;
      step();
    end
    wait_idle(40);

    // Single request, held to observe back-to-back launch spacing.
    req_data = 32'h33A52211;
    req      = 4'b0100;
    step();
    check("single_tx_start", tx_start, 1);
    check("single_ack", ack, 4'b0100);
    check("single_tx_data", tx_data, 8'hA5);
    check("single_grant_id", grant_id, 2);
    check("single_sched_busy", sched_busy, 1);
    for (int c = 2; c <= 14; c++) begin
      step();
      check("b2b_no_start", tx_start, 0);
      check("b2b_no_ack", ack, 0);
      if (c == 13) check("b2b_busy_c13", sched_busy, 1);
      if (c == 14) check("b2b_idle_c14", sched_busy, 0);
    end
    step();
    check("b2b_start_c15", tx_start, 1);
    check("b2b_ack_c15", ack, 4'b0100);
    req = 4'b0000;
    step();
    check("tx_data_hold", tx_data, 8'hA5);
    wait_idle(40);

    // Withdrawal: pointer at 2, requesters 1 and 2 pending; 1 wins.
    req_data = 32'h44C35A11;
    req      = 4'b0110;
    step();
    check("wd_ack", ack, 4'b0010);
    check("wd_grant_id", grant_id, 1);
    check("wd_tx_data", tx_data, 8'h5A);
    req = 4'b0100;
    step();
    wait_launch(40);
    check("wd_next_ack", ack, 4'b0100);
    check("wd_next_grant", grant_id, 2);
    check("wd_next_data", tx_data, 8'hC3);
    req = 4'b0000;
    step();
    wait_idle(40);
    for (int i = 0; i < 4; i++) begin
      step();
      check("wd_quiet", {ack, tx_start}, 0);
    end

    // Reset during WAIT_DONE; pointer returns to 3 so requester 0 wins next.
    req_data = 32'h77000066;
    req      = 4'b1000;
    step();
    check("mid_ack", ack, 4'b1000);
    req = 4'b0000;
    repeat (5) step();
    check("mid_in_frame", {tx_busy, sched_busy}, 2'b11);
    reset_n = 1'b0;
    req     = 4'b1001;
    #1;
    check("mid_rst_sched_busy", sched_busy, 0);
    check("mid_rst_grant_id", grant_id, 0);
    check("mid_rst_tx_data", tx_data, 0);
    step();
    check("mid_rst_ack", ack, 0);
    reset_n = 1'b1;
    wait_launch(40);
    check("mid_first_grant", grant_id, 0);
    check("mid_first_ack", ack, 4'b0001);
    check("mid_first_data", tx_data, 8'h66);
    req = 4'b0000;
    step();
    wait_idle(40);

    // Transmitter never goes busy.
    model_en = 1'b0;
    req      = 4'b0001;
    step();
    check("to_ack", ack, 4'b0001);
    req = 4'b0000;
    repeat (4) step();
    check("to_err_c5", err_timeout, 0);
    check("to_busy_c5", sched_busy, 1);
    step();
`ifdef UART_TX_SCHED_TIMEOUT_EN
    check("to_err_set", err_timeout, 1);
    check("to_idle", sched_busy, 0);
    model_en = 1'b1;
    req_data = 32'h0000BB00;
    req      = 4'b0010;
    step();
    check("to_next_ack", ack, 4'b0010);
    check("to_next_grant", grant_id, 1);
    check("to_next_data", tx_data, 8'hBB);
    check("to_err_sticky", err_timeout, 1);
    req = 4'b0000;
    step();
    wait_idle(40);
`else
    check("to_err_zero", err_timeout, 0);
    check("to_stuck", sched_busy, 1);
    repeat (10) step();
    check("to_still_stuck", sched_busy, 1);
    check("to_err_still_zero", err_timeout, 0);
    model_en = 1'b1;
`endif
    reset_n = 1'b0;
    #1;
    check("final_rst_busy", sched_busy, 0);
    check("final_rst_err", err_timeout, 0);
    step();
    reset_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares one `uart_Tx` byte transmitter between `NUM_REQ` byte producers. It arbitrates pending requests and captures the winner's byte. It pulses the transmitter's start input, then holds off the next launch until the frame has fully left the line. It sits between the producer blocks and the transmitter's `transmit`/`TxData`/`busy` pins.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8).
- `ID_W`, 2, grant index width; must equal clog2(`NUM_REQ`).
- `TIMEOUT`, 4, cycles allowed in WAIT_BUSY before abort (used only with the Configuration macro).

- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  `NUM_REQ`  per-requester byte-pending level.
- `req_data`  in  `NUM_REQ`*8  byte of requester i at bits [8i+7:8i].
- `ack`  out  `NUM_REQ`  one-cycle pulse: requester's byte was launched.
- `tx_start`  out  1  to transmitter `transmit`; one-cycle pulse.
- `tx_data`  out  8  to transmitter `TxData`; registered.
- `tx_busy`  in  1  from transmitter `busy`.
- `grant_id`  out  `ID_W`  index of the most recent grant.
- `sched_busy`  out  1  high whenever state is not IDLE.
- `err_timeout`  out  1  sticky timeout flag; cleared only by reset.

## Operation
- States:
  - IDLE: if `req` != 0 and `tx_busy` = 0, pick the winner, capture `req_data` of the winner into `tx_data`, load `grant_id`, and go to LAUNCH. Otherwise stay.
  - LAUNCH: `tx_start` = 1 and `ack[grant_id]` = 1 for exactly this cycle. Go to WAIT_BUSY.
  - WAIT_BUSY: on `tx_busy` = 1, go to WAIT_DONE.
  - WAIT_DONE: on `tx_busy` = 0, go to IDLE and update the round-robin pointer to `grant_id`.
- Arbitration:
  - Search starts at pointer+1 and wraps modulo `NUM_REQ`. The first set `req` bit wins.
  - The pointer resets to `NUM_REQ`-1, so requester 0 has priority after reset.
- Requester rules:
  - Hold `req` and `req_data` stable until `ack`.
  - Data is sampled only in the IDLE grant cycle.
  - Deasserting `req` after the grant cycle does not cancel: the captured byte is still launched and acked.
  - A requester that keeps `req` high after its `ack` is re-arbitrated normally; it is not re-served until the others have had a turn.
- Only one `ack` bit is ever high; `ack` is never high outside LAUNCH.
- `tx_data` holds the last captured byte until the next grant.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Any in-flight frame at the transmitter is the transmitter's concern; no `ack` is issued after reset.

## Timing
- Reset values:
  - `tx_start`=0, `tx_data`=0, `ack`=0, `grant_id`=0, `sched_busy`=0, `err_timeout`=0.
  - State=IDLE, pointer=`NUM_REQ`-1.
- Latency: `req` seen in IDLE at cycle 0 gives `tx_start`/`ack` at cycle 1. The transmitter raises `busy` at cycle 2.
- Back-to-back: with an 11-cycle frame (start, 8 data, parity, stop), busy covers cycles 2..12. WAIT_DONE sees busy=0 at cycle 13 and is in IDLE at cycle 14. The next `tx_start` is at cycle 15.
- `sched_busy` is high from cycle 1 through the last WAIT_DONE cycle.
- All outputs are registered; none depends combinationally on `req` or `tx_busy`.

## Configuration
- Macro: `UART_TX_SCHED_TIMEOUT_EN`.
- Defined:
  - A counter runs in WAIT_BUSY. If `tx_busy` is still 0 after `TIMEOUT` cycles, set `err_timeout` and return to IDLE.
  - The pointer is updated as on normal completion.
  - The `ack` already issued stands.
- Undefined:
  - No counter; WAIT_BUSY waits indefinitely.
  - `err_timeout` is tied to 0.
  - `TIMEOUT` is ignored.

## Test plan
- Reset: hold `reset_n`=0 with `req`=4'b1111. Required: all outputs at reset values; no `ack` or `tx_start` until after release.
- Single request: `req`=4'b0100, `req_data[23:16]`=8'hA5, transmitter model busy for 11 cycles. Required: `tx_start` and `ack`=4'b0100 at cycle 1, `tx_data`=8'hA5, `grant_id`=2, next launch no earlier than cycle 15.
- Round robin: `req`=4'b1111 held for 5 frames. Required: grant order 0,1,2,3,0 and exactly one `ack` bit per frame.
- Withdrawal: `req[1]` dropped in the LAUNCH cycle. Required: byte still launched, `ack[1]` pulses, and requester 1 is not granted again while `req[1]`=0.
- Reset mid-frame: assert `reset_n`=0 during WAIT_DONE. Required: `sched_busy`=0 immediately; after release, the first grant goes to requester 0 if requesting.
- Timeout (macro defined, `TIMEOUT`=4): transmitter model never raises busy. Required: `err_timeout`=1 four cycles after entering WAIT_BUSY, return to IDLE, and the next request is served. Without the macro: `sched_busy` stays 1 and `err_timeout`=0.
